// File: rtl/accel_shell_pkg.sv
// Shared register map, ap_ctrl bit positions and read-channel state encoding
// for the AXI-Lite / AXI-Stream accelerator shell.
package accel_shell_pkg;

  localparam int unsigned REG_OFS_W = 8;

  localparam logic [REG_OFS_W-1:0] ADDR_AP_CTRL = 8'h00;
  localparam logic [REG_OFS_W-1:0] ADDR_LEN     = 8'h10;
  localparam logic [REG_OFS_W-1:0] ADDR_STATUS  = 8'h14;

  localparam int unsigned AP_START_BIT = 0;
  localparam int unsigned AP_DONE_BIT  = 1;
  localparam int unsigned AP_IDLE_BIT  = 2;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } rd_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with occupancy count; push while full is accepted only
// when a pop happens in the same cycle. Head reads 0 while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 33,
  parameter int unsigned DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         din,
  input  logic                     pop,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic [WIDTH-1:0]         head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [PW:0]      cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop && (cnt != '0);
  assign do_push = push && ((cnt != FULL_CNT) || do_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + (PW+1)'(1);
        2'b01:   cnt <= cnt - (PW+1)'(1);
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage carries no reset; visibility is gated by the count instead.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign full  = (cnt == FULL_CNT);
  assign empty = (cnt == '0);
  assign count = cnt;
  assign head  = empty ? '0 : mem[rd_ptr];

endmodule

// File: rtl/axil_axis_accel_shell.sv
// Accelerator-side AXI-Lite register file plus ingress/egress stream FIFOs,
// exposing a pop/push strobe interface and ap_start/core_done to the core.
module axil_axis_accel_shell
  import accel_shell_pkg::*;
#(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 12,
  parameter int unsigned DW    = 32
) (
  input  logic          axis_clk,
  input  logic          axis_rst_n,
  input  logic          awvalid,
  output logic          awready,
  input  logic [AW-1:0] awaddr,
  input  logic          wvalid,
  output logic          wready,
  input  logic [DW-1:0] wdata,
  input  logic          arvalid,
  output logic          arready,
  input  logic [AW-1:0] araddr,
  output logic          rvalid,
  input  logic          rready,
  output logic [DW-1:0] rdata,
  input  logic          ss_tvalid,
  output logic          ss_tready,
  input  logic [DW-1:0] ss_tdata,
  input  logic          ss_tlast,
  output logic          sm_tvalid,
  input  logic          sm_tready,
  output logic [DW-1:0] sm_tdata,
  output logic          sm_tlast,
  output logic          ap_start,
  input  logic          core_done,
  output logic [DW-1:0] data_len,
  input  logic          in_pop,
  output logic [DW-1:0] in_data,
  output logic          in_last,
  output logic          in_empty,
  input  logic          out_push,
  input  logic [DW-1:0] out_data,
  input  logic          out_last,
  output logic          out_full
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  logic                 aw_held, w_held, aw_held_d, w_held_d;
  logic                 aw_hs, w_hs, commit, start_ok, rd_clear;
  logic [REG_OFS_W-1:0] wr_ofs;
  logic [DW-1:0]        wr_data;
  logic                 busy, done;
  rd_state_e            state_q, state_d;
  logic                 rd_ctrl_q, rd_ctrl_d;
  logic [DW-1:0]        rdata_d, rd_mux;
  logic                 in_full, eg_empty;
  logic [CW-1:0]        in_count, eg_count;
  logic [DW:0]          in_head, eg_head;
  logic                 unused_addr_hi;

  assign unused_addr_hi = ^{awaddr[AW-1:REG_OFS_W], araddr[AW-1:REG_OFS_W]};

  // Write channel: address and data captured independently, committed together.
  assign aw_hs     = awvalid && awready;
  assign w_hs      = wvalid && wready;
  assign commit    = aw_held && w_held;
  assign aw_held_d = !commit && (aw_hs || aw_held);
  assign w_held_d  = !commit && (w_hs || w_held);
  assign start_ok  = commit && (wr_ofs == ADDR_AP_CTRL) && wr_data[AP_START_BIT] && !busy;
  assign rd_clear  = rvalid && rready && rd_ctrl_q;

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      awready  <= 1'b0;
      wready   <= 1'b0;
      wr_ofs   <= '0;
      wr_data  <= '0;
      data_len <= '0;
      ap_start <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      aw_held  <= aw_held_d;
      w_held   <= w_held_d;
      awready  <= !aw_held_d;
      wready   <= !w_held_d;
      if (aw_hs) wr_ofs  <= awaddr[REG_OFS_W-1:0];
      if (w_hs)  wr_data <= wdata;
      if (commit && (wr_ofs == ADDR_LEN)) data_len <= wr_data;
      ap_start <= start_ok;
      // core_done is applied last so completion beats a read-clear
      if (start_ok || rd_clear) done <= 1'b0;
      if (start_ok)             busy <= 1'b1;
      if (core_done) begin
        done <= 1'b1;
        busy <= 1'b0;
      end
    end
  end

  always_comb begin
    rd_mux = '0;
    case (araddr[REG_OFS_W-1:0])
      ADDR_AP_CTRL: begin
        rd_mux[AP_START_BIT] = busy;
        rd_mux[AP_DONE_BIT]  = done;
        rd_mux[AP_IDLE_BIT]  = !busy;
      end
      ADDR_LEN:    rd_mux = data_len;
      ADDR_STATUS: rd_mux[15:0] = {8'(eg_count), 8'(in_count)};
      default:     rd_mux = '0;
    endcase
  end

  // Read channel next-state; arready/rvalid/rdata are registered from it.
  always_comb begin
    state_d   = state_q;
    rdata_d   = rdata;
    rd_ctrl_d = rd_ctrl_q;
    case (state_q)
      R_IDLE: begin
        if (arvalid && arready) begin
          state_d   = R_DATA;
          rdata_d   = rd_mux;
          rd_ctrl_d = (araddr[REG_OFS_W-1:0] == ADDR_AP_CTRL);
        end
      end
      R_DATA: begin
        if (rvalid && rready) state_d = R_IDLE;
      end
      default: state_d = R_IDLE;
    endcase
  end

  always_ff @(posedge axis_clk or negedge axis_rst_n) begin
    if (!axis_rst_n) begin
      state_q   <= R_IDLE;
      arready   <= 1'b0;
      rvalid    <= 1'b0;
      rdata     <= '0;
      rd_ctrl_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      arready   <= (state_d == R_IDLE);
      rvalid    <= (state_d == R_DATA);
      rdata     <= rdata_d;
      rd_ctrl_q <= rd_ctrl_d;
    end
  end

  sync_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_ingress (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .push  (ss_tvalid && ss_tready),
    .din   ({ss_tlast, ss_tdata}),
    .pop   (in_pop),
    .full  (in_full),
    .empty (in_empty),
    .count (in_count),
    .head  (in_head)
  );

  sync_fifo #(.WIDTH(DW + 1), .DEPTH(DEPTH)) u_egress (
    .clk   (axis_clk),
    .rst_n (axis_rst_n),
    .push  (out_push),
    .din   ({out_last, out_data}),
    .pop   (sm_tvalid && sm_tready),
    .full  (out_full),
    .empty (eg_empty),
    .count (eg_count),
    .head  (eg_head)
  );

  assign ss_tready = !in_full;
  assign in_data   = in_head[DW-1:0];
  assign in_last   = in_head[DW];
  assign sm_tvalid = !eg_empty;
  assign sm_tdata  = eg_head[DW-1:0];
  assign sm_tlast  = eg_head[DW];

endmodule

// File: tb/tb_axil_axis_accel_shell.sv
// Self-checking bench for axil_axis_accel_shell: register table, handshake
// sequences, stream corner cases and randomized FIFO traffic against queues.
module tb_axil_axis_accel_shell;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned AW    = 12;
  localparam int unsigned DW    = 32;

  logic          axis_clk = 1'b0;
  logic          axis_rst_n = 1'b0;
  logic          awvalid = 1'b0, awready;
  logic [AW-1:0] awaddr = '0;
  logic          wvalid = 1'b0, wready;
  logic [DW-1:0] wdata = '0;
  logic          arvalid = 1'b0, arready;
  logic [AW-1:0] araddr = '0;
  logic          rvalid, rready = 1'b0;
  logic [DW-1:0] rdata;
  logic          ss_tvalid = 1'b0, ss_tready;
  logic [DW-1:0] ss_tdata = '0;
  logic          ss_tlast = 1'b0;
  logic          sm_tvalid, sm_tready = 1'b0;
  logic [DW-1:0] sm_tdata;
  logic          sm_tlast;
  logic          ap_start, core_done = 1'b0;
  logic [DW-1:0] data_len;
  logic          in_pop = 1'b0;
  logic [DW-1:0] in_data;
  logic          in_last, in_empty;
  logic          out_push = 1'b0;
  logic [DW-1:0] out_data = '0;
  logic          out_last = 1'b0;
  logic          out_full;

  always #5 axis_clk = ~axis_clk;

  axil_axis_accel_shell #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .axis_clk(axis_clk), .axis_rst_n(axis_rst_n),
    .awvalid(awvalid), .awready(awready), .awaddr(awaddr),
    .wvalid(wvalid), .wready(wready), .wdata(wdata),
    .arvalid(arvalid), .arready(arready), .araddr(araddr),
    .rvalid(rvalid), .rready(rready), .rdata(rdata),
    .ss_tvalid(ss_tvalid), .ss_tready(ss_tready), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast),
    .sm_tvalid(sm_tvalid), .sm_tready(sm_tready), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast),
    .ap_start(ap_start), .core_done(core_done), .data_len(data_len),
    .in_pop(in_pop), .in_data(in_data), .in_last(in_last), .in_empty(in_empty),
    .out_push(out_push), .out_data(out_data), .out_last(out_last), .out_full(out_full)
  );

  typedef struct {
    logic [AW-1:0] addr;
    logic [DW-1:0] wr;
    logic [DW-1:0] exp_rd;
  } vec_t;

  int          n_checks = 0;
  int          n_fail = 0;
  int          start_pulses = 0;
  vec_t        vecs[6];
  logic [DW:0] qi[$];
  logic [DW:0] qe[$];
  logic [DW:0] got[$];
  logic [DW:0] exp_eg[3];

  always @(negedge axis_clk) if (ap_start) start_pulses++;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual 0x%0h required 0x%0h", name, act, exp);
    end
  endtask

  task automatic axil_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
    awaddr = a; wdata = d; awvalid = 1'b1; wvalid = 1'b1;
    for (int i = 0; i < 50 && (awvalid || wvalid); i++) begin
      logic ah, wh;
      ah = awvalid && awready;
      wh = wvalid && wready;
      @(negedge axis_clk);
      if (ah) awvalid = 1'b0;
      if (wh) wvalid = 1'b0;
    end
    check("wr_handshake_timeout", 64'({awvalid, wvalid}), 64'(0));
    awvalid = 1'b0; wvalid = 1'b0;
    @(negedge axis_clk);
  endtask

  task automatic axil_read(input logic [AW-1:0] a, input logic pulse_done, output logic [DW-1:0] d);
    araddr = a; arvalid = 1'b1; rready = 1'b0;
    for (int i = 0; i < 50 && arvalid; i++) begin
      logic hs;
      hs = arvalid && arready;
      @(negedge axis_clk);
      if (hs) arvalid = 1'b0;
    end
    arvalid = 1'b0;
    check("rd_latency_rvalid", 64'(rvalid), 64'(1));
    d = rdata;
    rready = 1'b1; core_done = pulse_done;
    @(negedge axis_clk);
    rready = 1'b0; core_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_flags"},
          64'({awready, wready, arready, rvalid, ap_start, ss_tready, sm_tvalid, sm_tlast, in_empty, out_full}),
          64'(10'b0000010010));
    check({tag, "_rdata"}, 64'(rdata), 64'(0));
    check({tag, "_data_len"}, 64'(data_len), 64'(0));
    check({tag, "_sm_tdata"}, 64'(sm_tdata), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [DW-1:0] rd;
    logic          prev_stall;
    logic [DW:0]   prev_head;
    logic          ipush, ipop, epush, epop;

    vecs[0] = '{12'h010, 32'h0000_0040, 32'h0000_0040};
    vecs[1] = '{12'h010, 32'hDEAD_BEEF, 32'hDEAD_BEEF};
    vecs[2] = '{12'h024, 32'h1234_5678, 32'h0000_0000};
    vecs[3] = '{12'h014, 32'hFFFF_FFFF, 32'h0000_0000};
    vecs[4] = '{12'h110, 32'h0000_00A5, 32'h0000_00A5};
    vecs[5] = '{12'h0FC, 32'h0000_0001, 32'h0000_0000};
    exp_eg[0] = {1'b0, 32'h11};
    exp_eg[1] = {1'b0, 32'h22};
    exp_eg[2] = {1'b1, 32'h33};

    // Reset state
    #12;
    check_reset_outputs("rst_in_reset");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    @(negedge axis_clk);
    check("rst_readies_after_release", 64'({awready, wready, arready}), 64'(3'b111));
    axil_read(12'h000, 1'b0, rd);
    check("rst_ap_ctrl_idle", 64'(rd), 64'(32'h4));

    // Register table: write then read back
    for (int i = 0; i < 6; i++) begin
      axil_write(vecs[i].addr, vecs[i].wr);
      axil_read(vecs[i].addr, 1'b0, rd);
      check($sformatf("table_rd_%0d", i), 64'(rd), 64'(vecs[i].exp_rd));
    end
    check("table_data_len_port", 64'(data_len), 64'(32'hA5));

    // Simultaneous aw + w
    axil_write(12'h010, 32'h0);
    awaddr = 12'h010; wdata = 32'h40; awvalid = 1'b1; wvalid = 1'b1;
    check("sim_readies_before", 64'({awready, wready}), 64'(2'b11));
    @(negedge axis_clk);
    awvalid = 1'b0; wvalid = 1'b0;
    check("sim_readies_drop", 64'({awready, wready}), 64'(2'b00));
    @(negedge axis_clk);
    check("sim_readies_back", 64'({awready, wready}), 64'(2'b11));
    check("sim_data_len", 64'(data_len), 64'(32'h40));

    // Staggered: aw three cycles before w
    axil_write(12'h010, 32'h0);
    awaddr = 12'h010; awvalid = 1'b1;
    @(negedge axis_clk);
    awvalid = 1'b0;
    check("stag_aw_held", 64'({awready, wready}), 64'(2'b01));
    @(negedge axis_clk);
    @(negedge axis_clk);
    check("stag_len_not_yet", 64'(data_len), 64'(0));
    wdata = 32'h40; wvalid = 1'b1;
    @(negedge axis_clk);
    wvalid = 1'b0;
    check("stag_both_low", 64'({awready, wready}), 64'(2'b00));
    @(negedge axis_clk);
    check("stag_readies_back", 64'({awready, wready}), 64'(2'b11));
    check("stag_data_len", 64'(data_len), 64'(32'h40));

    // ap_start / core_done / read-clear
    axil_write(12'h000, 32'h1);
    repeat (2) @(negedge axis_clk);
    check("start_pulse_count", 64'(start_pulses), 64'(1));
    axil_read(12'h000, 1'b0, rd);
    check("start_busy_read", 64'(rd), 64'(32'h1));
    axil_write(12'h000, 32'h1);
    repeat (2) @(negedge axis_clk);
    check("start_ignored_busy", 64'(start_pulses), 64'(1));
    core_done = 1'b1;
    @(negedge axis_clk);
    core_done = 1'b0;
    axil_read(12'h000, 1'b0, rd);
    check("done_read", 64'(rd), 64'(32'h6));
    axil_read(12'h000, 1'b0, rd);
    check("done_cleared_read", 64'(rd), 64'(32'h4));

    // core_done coincides with the read-clear handshake: done survives
    axil_write(12'h000, 32'h1);
    repeat (2) @(negedge axis_clk);
    check("restart_pulse_count", 64'(start_pulses), 64'(2));
    axil_read(12'h000, 1'b1, rd);
    check("collide_busy_read", 64'(rd), 64'(32'h1));
    axil_read(12'h000, 1'b0, rd);
    check("collide_done_kept", 64'(rd), 64'(32'h6));
    axil_read(12'h000, 1'b0, rd);
    check("collide_then_clear", 64'(rd), 64'(32'h4));

    // Egress with toggling sm_tready
    prev_stall = 1'b0; prev_head = '0;
    for (int c = 0; c < 20; c++) begin
      if (prev_stall) check("eg_stall_stable", 64'({sm_tlast, sm_tdata}), 64'(prev_head));
      out_push  = (c < 3);
      out_data  = (c < 3) ? exp_eg[c][DW-1:0] : '0;
      out_last  = (c < 3) ? exp_eg[c][DW] : 1'b0;
      sm_tready = c[0];
      if (sm_tvalid && sm_tready) got.push_back({sm_tlast, sm_tdata});
      prev_stall = sm_tvalid && !sm_tready;
      prev_head  = {sm_tlast, sm_tdata};
      @(negedge axis_clk);
    end
    out_push = 1'b0; out_last = 1'b0; sm_tready = 1'b0;
    check("eg_beat_count", 64'(got.size()), 64'(3));
    for (int i = 0; i < 3 && i < got.size(); i++)
      check($sformatf("eg_beat_%0d", i), 64'(got[i]), 64'(exp_eg[i]));

    // Ingress backpressure with DEPTH beats, then one more after a pop
    for (int k = 0; k < 8; k++) begin
      ss_tdata = 32'hA0 + 32'(k); ss_tlast = 1'b0; ss_tvalid = 1'b1;
      check($sformatf("ing_ready_%0d", k), 64'(ss_tready), 64'(1));
      @(negedge axis_clk);
    end
    ss_tdata = 32'hA8; ss_tlast = 1'b1;
    check("ing_full_backpressure", 64'(ss_tready), 64'(0));
    axil_read(12'h014, 1'b0, rd);
    check("ing_status_full", 64'(rd), 64'(32'h08));
    check("ing_head_first", 64'({in_last, in_data}), 64'({1'b0, 32'hA0}));
    in_pop = 1'b1;
    @(negedge axis_clk);
    in_pop = 1'b0;
    check("ing_ready_after_pop", 64'(ss_tready), 64'(1));
    @(negedge axis_clk);
    ss_tvalid = 1'b0; ss_tlast = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      check($sformatf("ing_order_%0d", k), 64'({in_empty, in_last, in_data}),
            64'({1'b0, (k == 8), 32'hA0 + 32'(k)}));
      in_pop = 1'b1;
      @(negedge axis_clk);
      in_pop = 1'b0;
    end
    check("ing_empty_after_drain", 64'(in_empty), 64'(1));
    in_pop = 1'b1;
    @(negedge axis_clk);
    in_pop = 1'b0;
    axil_read(12'h014, 1'b0, rd);
    check("ing_pop_empty_ignored", 64'(rd), 64'(0));

    // Randomized stream traffic against queue models
    for (int c = 0; c < 400; c++) begin
      check("rnd_ss_tready", 64'(ss_tready), 64'(qi.size() < DEPTH));
      check("rnd_in_empty", 64'(in_empty), 64'(qi.size() == 0));
      if (qi.size() > 0) check("rnd_in_head", 64'({in_last, in_data}), 64'(qi[0]));
      check("rnd_sm_tvalid", 64'(sm_tvalid), 64'(qe.size() > 0));
      check("rnd_out_full", 64'(out_full), 64'(qe.size() == DEPTH));
      if (qe.size() > 0) check("rnd_sm_head", 64'({sm_tlast, sm_tdata}), 64'(qe[0]));
      ss_tvalid = 1'($urandom_range(0, 1));
      ss_tdata  = $urandom;
      ss_tlast  = 1'($urandom_range(0, 1));
      out_push  = (c < 200) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
      out_data  = $urandom;
      out_last  = 1'($urandom_range(0, 1));
      in_pop    = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      sm_tready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      ipop  = in_pop && (qi.size() > 0);
      ipush = ss_tvalid && (qi.size() < DEPTH);
      epop  = sm_tready && (qe.size() > 0);
      epush = out_push && ((qe.size() < DEPTH) || epop);
      if (ipop)  void'(qi.pop_front());
      if (ipush) qi.push_back({ss_tlast, ss_tdata});
      if (epop)  void'(qe.pop_front());
      if (epush) qe.push_back({out_last, out_data});
      @(negedge axis_clk);
    end
    ss_tvalid = 1'b0; out_push = 1'b0; in_pop = 1'b0; sm_tready = 1'b0;
    axil_read(12'h014, 1'b0, rd);
    check("rnd_status", 64'(rd), 64'({16'h0, 8'(qe.size()), 8'(qi.size())}));

    // Drain, then half-fill both FIFOs and hold a read in the data phase
    in_pop = 1'b1; sm_tready = 1'b1;
    repeat (DEPTH + 1) @(negedge axis_clk);
    in_pop = 1'b0; sm_tready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      ss_tvalid = 1'b1; ss_tdata = 32'h50 + 32'(k);
      out_push = 1'b1; out_data = 32'h60 + 32'(k);
      @(negedge axis_clk);
    end
    ss_tvalid = 1'b0; out_push = 1'b0;
    araddr = 12'h010; arvalid = 1'b1;
    @(negedge axis_clk);
    arvalid = 1'b0;
    check("pre_rst_rdata_phase", 64'({rvalid, rdata}), 64'({1'b1, 32'h40}));
    check("pre_rst_fifos", 64'({in_empty, sm_tvalid}), 64'(2'b01));
    #2 axis_rst_n = 1'b0;
    #1 check_reset_outputs("midrst");
    @(negedge axis_clk);
    axis_rst_n = 1'b1;
    @(negedge axis_clk);
    @(negedge axis_clk);
    check("midrst_readies_back", 64'({awready, wready, arready, rvalid}), 64'(4'b1110));
    axil_read(12'h014, 1'b0, rd);
    check("midrst_status", 64'(rd), 64'(0));
    axil_read(12'h000, 1'b0, rd);
    check("midrst_ap_ctrl", 64'(rd), 64'(32'h4));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/axil_axis_accel_shell.md
Name: axil_axis_accel_shell

Overview:
Accelerator-side responder for the Wishbone-to-AXI bridge in the user project. It terminates the AXI-Lite control interface (ap_ctrl register file) and the AXI-Stream ingress/egress ports, and presents a simple FIFO/strobe interface to a compute core such as the sort engine. It is the slave end that the bridge's AXI-Lite and AXI-Stream initiator logic talks to.

Parameters:
DEPTH, 8, entries per stream FIFO (power of two, >=2)
AW, 12, AXI-Lite address width
DW, 32, data width for AXI-Lite and AXI-Stream

Ports:
axis_clk  in  1  clock, all logic on rising edge
axis_rst_n  in  1  reset, asynchronous, active-low
awvalid/awready  in/out  1/1  AXI-Lite write address handshake
awaddr  in  AW  write byte address
wvalid/wready  in/out  1/1  AXI-Lite write data handshake
wdata  in  DW  write data
arvalid/arready  in/out  1/1  AXI-Lite read address handshake
araddr  in  AW  read byte address
rvalid/rready  out/in  1/1  AXI-Lite read data handshake
rdata  out  DW  read data
ss_tvalid/ss_tready  in/out  1/1  ingress stream handshake
ss_tdata/ss_tlast  in  DW/1  ingress beat
sm_tvalid/sm_tready  out/in  1/1  egress stream handshake
sm_tdata/sm_tlast  out  DW/1  egress beat
ap_start  out  1  one-cycle start pulse to core
core_done  in  1  one-cycle completion pulse from core
data_len  out  DW  length register value
in_pop  in  1  core pops ingress FIFO head
in_data/in_last/in_empty  out  DW/1/1  ingress FIFO head and status
out_push  in  1  core pushes egress beat
out_data/out_last  in  DW/1  egress beat from core
out_full  out  1  egress FIFO full

Behaviour:
- Reset: awready=wready=arready=1 once reset deasserts (0 during reset); rvalid=0, rdata=0, ap_start=0, busy=0, done=0, data_len=0, both FIFOs empty (ss_tready=1, sm_tvalid=0, sm_tdata=0, sm_tlast=0, in_empty=1, out_full=0).
- Write path: address and data latched independently. awready drops the cycle after an aw handshake; wready drops the cycle after a w handshake. Commit happens the cycle both are held (same-cycle aw+w commits on the next edge). Both readies reassert the cycle after commit. There is no B channel.
- Read FSM, states R_IDLE and R_DATA:
  - In R_IDLE, arready=1. arvalid&&arready latches the decoded register into rdata and moves to R_DATA.
  - In R_DATA, arready=0 and rvalid=1 with rdata stable. rvalid&&rready returns to R_IDLE.
  - Latency: rvalid rises 1 cycle after the ar handshake.
- Register map (byte offset, low 8 bits decoded):
  - 0x00 ap_ctrl: bit0 ap_start (reads busy), bit1 ap_done, bit2 ap_idle (=!busy).
  - 0x10 data_len: RW.
  - 0x14 status (RO): [7:0] ingress count, [15:8] egress count.
  - Other offsets read 0; writes to them are ignored.
- ap_start:
  - A write to 0x00 with wdata[0]=1 while !busy pulses ap_start for 1 cycle after commit, sets busy and clears done.
  - The same write while busy is ignored.
- core_done: clears busy and sets done.
- Read-clear of done: completion of a read of 0x00 (r handshake) clears done. If core_done and that read-clear occur in the same cycle, set wins.
- Ingress FIFO (DW+1 bits):
  - ss_tready=!full. Push on ss_tvalid&&ss_tready.
  - in_pop on empty is ignored.
  - Push and pop in the same cycle when not full: count unchanged.
- Egress FIFO:
  - sm_tvalid=!empty; head drives sm_tdata/sm_tlast. Pop on sm_tvalid&&sm_tready.
  - out_push while full is dropped.
  - Push and pop in the same cycle when full is permitted (count stays DEPTH).
- Pointers are log2(DEPTH) bits and wrap modulo DEPTH. Counts are log2(DEPTH)+1 bits.
- Asserting axis_rst_n low mid-transaction aborts immediately: every register and FIFO returns to its reset value and in-flight beats are lost.

Decomposition:
- Package accel_shell_pkg: register offsets (ADDR_AP_CTRL=0x00, ADDR_LEN=0x10, ADDR_STATUS=0x14), ap_ctrl bit indices, read-FSM state encoding.
- Sub-module sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count/head), instantiated twice at WIDTH=DW+1.

Test Plan:
- Write path, simultaneous aw+w: aw and w issued together, addr 0x010, data 0x0000_0040 -> both readies drop for 1 cycle, then reassert; data_len=0x40.
- Write path, staggered aw then w: aw at addr 0x010 three cycles before w, data 0x0000_0040 -> both readies drop for 1 cycle after commit, then reassert; data_len=0x40.
- ap_start and completion:
  - Write 0x00 with data 0x1 -> ap_start high exactly 1 cycle.
  - Read 0x00 -> 0x1.
  - Second start write while busy -> no pulse.
  - Pulse core_done -> read 0x00 returns 0x6, then a re-read returns 0x4.
- Ingress backpressure: push 9 beats 0xA0..0xA8 with DEPTH=8 -> ss_tready low after 8 beats; status[7:0]=8; after one in_pop, 0xA8 is accepted and the pop order is preserved.
- Egress with stalls: core pushes 0x11, 0x22, 0x33 (last on 0x33) while sm_tready toggles -> the sink receives 0x11, 0x22, 0x33 in order with tlast only on 0x33; sm_tdata is stable whenever stalled.
- Reset and read-clear collision:
  - Reset asserted during R_DATA and with both FIFOs half full -> all outputs at reset values the same cycle; after release, status reads 0.
  - core_done in the same cycle as the 0x00 read handshake -> done remains 1.
